// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo
// PS/2 keyboard receiver: synchronises and debounces the keyboard lines,
// deserialises 11-bit frames, validates start/parity/stop, optionally folds
// E0/F0 prefix bytes into extended/release flags, and buffers the resulting
// key events in a small FIFO with a valid/ready consumer interface.
// Pipeline: stop-bit capture (N) -> check/decode (N+1) -> FIFO write (N+2).

module ps2_rx_fifo #(
    parameter int TIMEOUT_CYCLES = 3200,
    parameter int SAMPLE_DELAY   = 10,
    parameter int FIFO_DEPTH     = 8,
    parameter int DECODE_PREFIX  = 1
) (
    input  logic                                 clk32,
    input  logic                                 reset_n,
    input  logic                                 kbd_clk,
    input  logic                                 kbd_dat,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [7:0]                           out_code,
    output logic                                 out_extended,
    output logic                                 out_release,
    output logic                                 interrupt,
    output logic                                 frame_error,
    output logic                                 overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count
);

    // ------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int DW = (SAMPLE_DELAY > 0) ? $clog2(SAMPLE_DELAY + 1) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [DW-1:0] DEB_LOAD   = DW'(SAMPLE_DELAY);
    localparam logic [TW-1:0] TMO_LOAD   = TW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    localparam logic [7:0] BYTE_EXT = 8'hE0;
    localparam logic [7:0] BYTE_REL = 8'hF0;

    localparam logic [3:0] LAST_BIT = 4'd10;

    // Prefix decoder states
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXT     = 2'd1;
    localparam logic [1:0] ST_REL     = 2'd2;
    localparam logic [1:0] ST_EXT_REL = 2'd3;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    // Odd parity over data byte plus parity bit: XOR of all nine bits is 1.
    function automatic logic odd_parity_ok(input logic [8:0] bits);
        return ^bits;
    endfunction

    // ------------------------------------------------------------------
    // Input synchronisers (idle bus level is 1)
    // ------------------------------------------------------------------
    logic clk_meta_r;
    logic clk_sync_r;
    logic dat_meta_r;
    logic dat_sync_r;

    // Two-flop synchronisers for the asynchronous keyboard lines.
    always_ff @(posedge clk32) begin
        if (!reset_n) begin
            clk_meta_r <= 1'b1;
            clk_sync_r <= 1'b1;
            dat_meta_r <= 1'b1;
            dat_sync_r <= 1'b1;
        end else begin
            clk_meta_r <= kbd_clk;
            clk_sync_r <= clk_meta_r;
            dat_meta_r <= kbd_dat;
            dat_sync_r <= dat_meta_r;
        end
    end

    // ------------------------------------------------------------------
    // Clock filter
    // ------------------------------------------------------------------
    // The debounce counter reloads on the same edge the synchronised clock
    // changes (detected one stage early as meta != sync), so a clean edge is
    // accepted 2 + SAMPLE_DELAY + 1 cycles after it reaches the pin.
    logic [DW-1:0] deb_cnt_r;
    logic          filt_clk_r;
    logic          clk_change_s;
    logic          accept_s;
    logic          fall_s;

    // Decide whether the filtered clock takes a new level this cycle.
    always_comb begin
        clk_change_s = (clk_meta_r != clk_sync_r);
        if (!clk_change_s && (deb_cnt_r == {DW{1'b0}}) && (clk_sync_r != filt_clk_r)) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        fall_s = accept_s & ~clk_sync_r;
    end

    // Debounce counter and filtered clock level.
    always_ff @(posedge clk32) begin
        if (!reset_n) begin
            deb_cnt_r  <= {DW{1'b0}};
            filt_clk_r <= 1'b1;
        end else if (clk_change_s) begin
            deb_cnt_r  <= DEB_LOAD;
        end else if (deb_cnt_r != {DW{1'b0}}) begin
            deb_cnt_r  <= deb_cnt_r - DW'(1);
        end else if (accept_s) begin
            filt_clk_r <= clk_sync_r;
        end
    end

    // ------------------------------------------------------------------
    // Bit capture and inactivity timeout
    // ------------------------------------------------------------------
    logic [10:0]   shift_r;
    logic [3:0]    bit_cnt_r;
    logic [TW-1:0] tmo_cnt_r;
    logic          done_r;
    logic          tmo_hit_r;

    // Shift in one bit per accepted falling edge; abandon stalled frames.
    always_ff @(posedge clk32) begin
        if (!reset_n) begin
            shift_r   <= 11'd0;
            bit_cnt_r <= 4'd0;
            tmo_cnt_r <= {TW{1'b0}};
            done_r    <= 1'b0;
            tmo_hit_r <= 1'b0;
        end else begin
            done_r    <= 1'b0;
            tmo_hit_r <= 1'b0;
            if (fall_s) begin
                shift_r   <= {dat_sync_r, shift_r[10:1]};
                tmo_cnt_r <= TMO_LOAD;
                if (bit_cnt_r == LAST_BIT) begin
                    bit_cnt_r <= 4'd0;
                    done_r    <= 1'b1;
                end else begin
                    bit_cnt_r <= bit_cnt_r + 4'd1;
                end
            end else if (tmo_cnt_r != {TW{1'b0}}) begin
                tmo_cnt_r <= tmo_cnt_r - TW'(1);
                if ((tmo_cnt_r == TW'(1)) && (bit_cnt_r != 4'd0)) begin
                    bit_cnt_r <= 4'd0;
                    tmo_hit_r <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame check and prefix decoder
    // ------------------------------------------------------------------
    logic [1:0] state_r;
    logic [1:0] state_next_s;
    logic       frame_ok_s;
    logic       ext_s;
    logic       rel_s;
    logic [7:0] byte_s;
    logic       push_s;
    logic       err_s;
    logic [9:0] entry_s;

    logic       push_req_r;
    logic [9:0] push_entry_r;
    logic       err_req_r;

    // Validate a completed frame and work out the decoder's next move.
    always_comb begin
        byte_s       = shift_r[8:1];
        frame_ok_s   = ~shift_r[0] & odd_parity_ok(shift_r[9:1]) & shift_r[10];
        ext_s        = (state_r == ST_EXT) || (state_r == ST_EXT_REL);
        rel_s        = (state_r == ST_REL) || (state_r == ST_EXT_REL);
        state_next_s = state_r;
        push_s       = 1'b0;
        err_s        = 1'b0;
        entry_s      = {2'b00, byte_s};
        if (tmo_hit_r) begin
            err_s        = 1'b1;
            state_next_s = ST_IDLE;
        end else if (done_r) begin
            if (!frame_ok_s) begin
                err_s        = 1'b1;
                state_next_s = ST_IDLE;
            end else if ((DECODE_PREFIX != 0) && (byte_s == BYTE_EXT)) begin
                case (state_r)
                    ST_IDLE:    state_next_s = ST_EXT;
                    ST_EXT:     state_next_s = ST_EXT;
                    ST_REL:     state_next_s = ST_EXT_REL;
                    ST_EXT_REL: state_next_s = ST_EXT_REL;
                    default:    state_next_s = ST_IDLE;
                endcase
            end else if ((DECODE_PREFIX != 0) && (byte_s == BYTE_REL)) begin
                case (state_r)
                    ST_IDLE:    state_next_s = ST_REL;
                    ST_EXT:     state_next_s = ST_EXT_REL;
                    ST_REL:     state_next_s = ST_REL;
                    ST_EXT_REL: state_next_s = ST_EXT_REL;
                    default:    state_next_s = ST_IDLE;
                endcase
            end else begin
                push_s       = 1'b1;
                state_next_s = ST_IDLE;
                if (DECODE_PREFIX != 0) begin
                    entry_s = {ext_s, rel_s, byte_s};
                end else begin
                    entry_s = {2'b00, byte_s};
                end
            end
        end else begin
            state_next_s = state_r;
        end
    end

    // Register decoder state and the push/error request for the FIFO stage.
    always_ff @(posedge clk32) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            push_req_r   <= 1'b0;
            push_entry_r <= 10'd0;
            err_req_r    <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            push_req_r   <= push_s;
            push_entry_r <= entry_s;
            err_req_r    <= err_s;
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    logic [9:0]    mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          interrupt_r;
    logic          frame_error_r;
    logic          overflow_r;
    logic          pop_s;
    logic          full_s;
    logic          wr_ok_s;
    logic [9:0]    head_s;

    // A push into a full FIFO still succeeds when the head leaves the same cycle.
    always_comb begin
        pop_s   = (count_r != {CW{1'b0}}) && out_ready;
        full_s  = (count_r == FULL_COUNT);
        wr_ok_s = push_req_r && (!full_s || pop_s);
        head_s  = mem_r[rd_ptr_r];
    end

    // Entry storage; contents are only visible through the valid-gated head.
    always_ff @(posedge clk32) begin
        if (wr_ok_s) begin
            mem_r[wr_ptr_r] <= push_entry_r;
        end
    end

    // Pointers, occupancy and one-cycle event pulses.
    always_ff @(posedge clk32) begin
        if (!reset_n) begin
            wr_ptr_r      <= {AW{1'b0}};
            rd_ptr_r      <= {AW{1'b0}};
            count_r       <= {CW{1'b0}};
            interrupt_r   <= 1'b0;
            frame_error_r <= 1'b0;
            overflow_r    <= 1'b0;
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= (wr_ptr_r == AW'(FIFO_DEPTH - 1)) ? {AW{1'b0}} : wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= (rd_ptr_r == AW'(FIFO_DEPTH - 1)) ? {AW{1'b0}} : rd_ptr_r + AW'(1);
            end
            case ({wr_ok_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            interrupt_r   <= wr_ok_s;
            overflow_r    <= push_req_r & ~wr_ok_s;
            frame_error_r <= err_req_r;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (head fields forced to 0 while the FIFO is empty)
    // ------------------------------------------------------------------
    assign out_valid    = (count_r != {CW{1'b0}});
    assign out_code     = out_valid ? head_s[7:0] : 8'h00;
    assign out_release  = out_valid ? head_s[8]   : 1'b0;
    assign out_extended = out_valid ? head_s[9]   : 1'b0;
    assign interrupt    = interrupt_r;
    assign frame_error  = frame_error_r;
    assign overflow     = overflow_r;
    assign fifo_count   = count_r;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: a prefix-decoding instance and a raw instance share
// the keyboard lines. A table of frames with hand-derived results, a few
// hand-written corner sequences, and a randomized run checked against an
// event-level model of the receiver.

module tb_ps2_rx_fifo;

    localparam int H     = 20;   // half bit period in clk32 cycles
    localparam int DEPTH = 8;

    logic       clk32 = 1'b0;
    logic       reset_n, kbd_clk, kbd_dat, out_ready, out_ready_raw;
    logic       out_valid, out_extended, out_release, interrupt, frame_error, overflow;
    logic [7:0] out_code;
    logic [3:0] fifo_count;
    logic       r_valid, r_extended, r_release, r_interrupt, r_frame_error, r_overflow;
    logic [7:0] r_code;
    logic [3:0] r_count;

    always #5 clk32 = ~clk32;

    ps2_rx_fifo #(.TIMEOUT_CYCLES(3200), .SAMPLE_DELAY(10), .FIFO_DEPTH(DEPTH), .DECODE_PREFIX(1)) dut (
        .clk32(clk32), .reset_n(reset_n), .kbd_clk(kbd_clk), .kbd_dat(kbd_dat),
        .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
        .out_extended(out_extended), .out_release(out_release), .interrupt(interrupt),
        .frame_error(frame_error), .overflow(overflow), .fifo_count(fifo_count));

    ps2_rx_fifo #(.TIMEOUT_CYCLES(3200), .SAMPLE_DELAY(10), .FIFO_DEPTH(DEPTH), .DECODE_PREFIX(0)) dut_raw (
        .clk32(clk32), .reset_n(reset_n), .kbd_clk(kbd_clk), .kbd_dat(kbd_dat),
        .out_valid(r_valid), .out_ready(out_ready_raw), .out_code(r_code),
        .out_extended(r_extended), .out_release(r_release), .interrupt(r_interrupt),
        .frame_error(r_frame_error), .overflow(r_overflow), .fifo_count(r_count));

    // ---------------- monitors (sample on falling edge) ----------------
    logic [9:0] got_q[$], got_raw_q[$];
    int int_cnt = 0, ferr_cnt = 0, ovf_cnt = 0;
    int rint_cnt = 0, rferr_cnt = 0, rovf_cnt = 0;

    always @(negedge clk32) begin
        if (out_valid && out_ready) got_q.push_back({out_extended, out_release, out_code});
        if (r_valid && out_ready_raw) got_raw_q.push_back({r_extended, r_release, r_code});
        if (interrupt)     int_cnt++;
        if (frame_error)   ferr_cnt++;
        if (overflow)      ovf_cnt++;
        if (r_interrupt)   rint_cnt++;
        if (r_frame_error) rferr_cnt++;
        if (r_overflow)    rovf_cnt++;
    end

    // ---------------- reference model (event level) ----------------
    logic [9:0] exp_q[$], exp_raw_q[$];
    bit m_ext = 0, m_rel = 0;
    int m_occ = 0;
    int m_int = 0, m_ferr = 0, m_ovf = 0, m_rint = 0, m_rferr = 0;

    int n_vec = 0, n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_frame(input logic [7:0] b, input bit good);
        if (!good) begin
            m_ext = 0; m_rel = 0; m_ferr++; m_rferr++;
        end else begin
            exp_raw_q.push_back({2'b00, b});
            m_rint++;
            if (b == 8'hE0) m_ext = 1;
            else if (b == 8'hF0) m_rel = 1;
            else begin
                if (!out_ready && m_occ == DEPTH) m_ovf++;
                else begin
                    exp_q.push_back({m_ext, m_rel, b});
                    m_int++;
                    if (!out_ready) m_occ++;
                end
                m_ext = 0; m_rel = 0;
            end
        end
    endtask

    task automatic model_timeout();
        m_ext = 0; m_rel = 0; m_ferr++; m_rferr++;
    endtask

    task automatic set_ready(input logic r);
        out_ready = r;
        if (r) m_occ = 0;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin @(posedge clk32); #1; end
    endtask

    task automatic send_bit(input logic b);
        kbd_dat = b; tick(H);
        kbd_clk = 1'b0; tick(H);
        kbd_clk = 1'b1;
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bp, input bit bs, input bit bst);
        logic par;
        par = (~^b) ^ bp;
        return {~bst, par, b, bs};
    endfunction

    task automatic send_frame(input logic [7:0] b, input bit bp, input bit bs, input bit bst);
        logic [10:0] f;
        f = make_frame(b, bp, bs, bst);
        for (int i = 0; i < 11; i++) send_bit(f[i]);
        kbd_dat = 1'b1; tick(H);
        model_frame(b, !(bp || bs || bst));
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits);
        logic [10:0] f;
        f = make_frame(b, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) send_bit(f[i]);
        kbd_dat = 1'b1;
    endtask

    task automatic compare_queues(input string tag);
        check({tag, "_qsize"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check({tag, "_entry"}, got_q[i], exp_q[i]);
        check({tag, "_raw_qsize"}, got_raw_q.size(), exp_raw_q.size());
        for (int i = 0; i < got_raw_q.size() && i < exp_raw_q.size(); i++)
            check({tag, "_raw_entry"}, got_raw_q[i], exp_raw_q[i]);
        got_q.delete(); exp_q.delete(); got_raw_q.delete(); exp_raw_q.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"},  out_valid, 0);
        check({tag, "_code"},   out_code, 0);
        check({tag, "_ext"},    out_extended, 0);
        check({tag, "_rel"},    out_release, 0);
        check({tag, "_irq"},    interrupt, 0);
        check({tag, "_ferr"},   frame_error, 0);
        check({tag, "_ovf"},    overflow, 0);
        check({tag, "_count"},  fifo_count, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] data;
        bit         bad_par;
        bit         bad_start;
        bit         bad_stop;
        bit         exp_push;
        logic [9:0] exp_entry;   // {ext, rel, code}
        bit         exp_err;
    } vec_t;

    vec_t tbl[17];

    initial begin
        #(10 * 300000);
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int i0, f0, o0, rf0;
        logic [7:0] b;
        int r, e;

        tbl[0]  = '{8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 10'h01C, 1'b0};
        tbl[1]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0};
        tbl[2]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0};
        tbl[3]  = '{8'h75, 1'b0, 1'b0, 1'b0, 1'b1, 10'h375, 1'b0};
        tbl[4]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0};
        tbl[5]  = '{8'h1C, 1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 1'b1};
        tbl[6]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0};
        tbl[7]  = '{8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 10'h11C, 1'b0};
        tbl[8]  = '{8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 1'b1};
        tbl[9]  = '{8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 10'h000, 1'b1};
        tbl[10] = '{8'hE1, 1'b0, 1'b0, 1'b0, 1'b1, 10'h0E1, 1'b0};
        tbl[11] = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0};
        tbl[12] = '{8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 10'h112, 1'b0};
        tbl[13] = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0};
        tbl[14] = '{8'h6B, 1'b0, 1'b0, 1'b0, 1'b1, 10'h26B, 1'b0};
        tbl[15] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 10'h0FF, 1'b0};
        tbl[16] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000, 1'b0};

        reset_n = 1'b0; kbd_clk = 1'b1; kbd_dat = 1'b1;
        out_ready = 1'b1; out_ready_raw = 1'b1;
        tick(3);
        check_outputs_zero("reset");
        reset_n = 1'b1;
        tick(5);

        // Table-driven frames, consumer always ready
        for (int i = 0; i < 17; i++) begin
            i0 = int_cnt; f0 = ferr_cnt;
            send_frame(tbl[i].data, tbl[i].bad_par, tbl[i].bad_start, tbl[i].bad_stop);
            tick(2);
            check("tbl_irq", int_cnt - i0, tbl[i].exp_push);
            check("tbl_ferr", ferr_cnt - f0, tbl[i].exp_err);
            if (tbl[i].exp_push) begin
                check("tbl_pops", got_q.size(), 1);
                if (got_q.size() > 0) check("tbl_entry", got_q[0], tbl[i].exp_entry);
            end else begin
                check("tbl_nopop", got_q.size(), 0);
            end
            check("tbl_count", fifo_count, 0);
            got_q.delete(); exp_q.delete();
        end
        compare_queues("table");

        // Overflow: nine frames into an eight-entry FIFO with no consumer
        set_ready(1'b0);
        i0 = int_cnt; o0 = ovf_cnt;
        for (int v = 1; v <= 9; v++) send_frame(8'(v), 1'b0, 1'b0, 1'b0);
        check("ovf_count", fifo_count, 8);
        check("ovf_pulses", ovf_cnt - o0, 1);
        check("ovf_irqs", int_cnt - i0, 8);
        check("ovf_head", {out_valid, out_extended, out_release, out_code}, 11'h401);
        tick(3);
        check("ovf_hold", {out_valid, out_code}, 9'h101);
        set_ready(1'b1);
        tick(12);
        check("ovf_drained", out_valid, 0);
        compare_queues("overflow");

        // Timeout: five bits then an idle bus
        f0 = ferr_cnt; rf0 = rferr_cnt;
        send_partial(8'h29, 5);
        tick(3400);
        model_timeout();
        check("tmo_ferr", ferr_cnt - f0, 1);
        check("tmo_ferr_raw", rferr_cnt - rf0, 1);
        send_frame(8'h29, 1'b0, 1'b0, 1'b0);
        compare_queues("timeout");

        // Glitch: short low pulse on the clock line while idle
        f0 = ferr_cnt;
        kbd_clk = 1'b0; tick(5); kbd_clk = 1'b1;
        tick(40);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        check("glitch_ferr", ferr_cnt - f0, 0);
        compare_queues("glitch");

        // Reset in the middle of a frame with an entry waiting in the FIFO
        set_ready(1'b0);
        send_frame(8'h33, 1'b0, 1'b0, 1'b0);
        check("prerst_count", fifo_count, 1);
        send_partial(8'h1C, 6);
        reset_n = 1'b0;
        tick(1);
        check_outputs_zero("midrst");
        tick(2);
        reset_n = 1'b1;
        m_ext = 0; m_rel = 0; m_occ = 0;
        got_q.delete(); exp_q.delete();
        set_ready(1'b1);
        tick(5);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        compare_queues("reset");

        // Randomized frames against the model
        for (int n = 0; n < 40; n++) begin
            set_ready(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
            r = $urandom_range(0, 9);
            if (r < 2)      b = 8'hE0;
            else if (r < 4) b = 8'hF0;
            else            b = 8'($urandom_range(0, 255));
            e = $urandom_range(0, 11);
            send_frame(b, e == 0, e == 1, e == 2);
        end
        set_ready(1'b1);
        tick(20);
        compare_queues("random");

        check("tot_irq", int_cnt, m_int);
        check("tot_ferr", ferr_cnt, m_ferr);
        check("tot_ovf", ovf_cnt, m_ovf);
        check("tot_irq_raw", rint_cnt, m_rint);
        check("tot_ferr_raw", rferr_cnt, m_rferr);
        check("tot_ovf_raw", rovf_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised PS/2 keyboard receiver. It deserialises and validates 11-bit PS/2 frames (start, parity and stop checks), optionally folds E0/F0 prefix bytes into flags, and buffers the decoded key events in a FIFO with a valid/ready output. It sits between the keyboard pins and the CPU keyboard port, and replaces the single-register, no-check receiver.

## Interface
- `TIMEOUT_CYCLES`, 3200: mid-frame inactivity limit in clk32 cycles (100 µs at 32 MHz).
- `SAMPLE_DELAY`, 10: number of cycles kbd_clk must be stable before the level is accepted.
- `FIFO_DEPTH`, 8: number of event entries. Power of two, ≥2.
- `DECODE_PREFIX`, 1: 1 folds E0/F0 prefixes into flags; 0 passes every byte through raw.
- `clk32` input 1: system clock, 32 MHz. One clock domain.
- `reset_n` input 1: synchronous, active-low reset.
- `kbd_clk` input 1: PS/2 clock line, asynchronous.
- `kbd_dat` input 1: PS/2 data line, asynchronous.
- `out_valid` output 1: FIFO head is valid.
- `out_ready` input 1: consumer accepts the head this cycle.
- `out_code` output 8: head scancode.
- `out_extended` output 1: head was preceded by E0.
- `out_release` output 1: head was preceded by F0 (break code).
- `interrupt` output 1: one-cycle pulse on every successful FIFO push.
- `frame_error` output 1: one-cycle pulse on a start, parity, stop or timeout error.
- `overflow` output 1: one-cycle pulse when an event is dropped because the FIFO is full.
- `fifo_count` output $clog2(FIFO_DEPTH+1): number of occupied entries.

## Operation
- **Input synchronisation**: kbd_clk and kbd_dat each pass through a 2-flop synchroniser. Both are reset to 1 (the idle bus level).
- **Clock filter**: any change on the synchronised clock reloads the debounce counter with SAMPLE_DELAY. The new level is accepted only after the counter reaches 0.
- **Bit capture**: a bit is captured once per accepted high→low transition of the filtered clock. The synchronised kbd_dat is shifted in LSB-first, and the bit counter increments from 0 to 10.
- **Frame check** at bit 11: bit0 must be 0, bits 1–8 form the data byte, bit9 must give odd parity over data plus parity, and bit10 must be 1.
  - Frame good: the byte goes to the decoder.
  - Frame bad: frame_error pulses, the byte is discarded, and the prefix state is cleared.
  - In both cases the bit counter returns to 0.
- **Timeout**: the counter reloads TIMEOUT_CYCLES on every captured bit.
  - If it expires with the bit count between 1 and 10, the partial frame is discarded, frame_error pulses and the count is cleared.
  - If it expires with the bit count at 0, there is no effect.
- **Prefix decoder** (DECODE_PREFIX=1): two flag registers, ext and rel.
  - Byte E0: set ext, no push.
  - Byte F0: set rel, no push.
  - Any other byte (including E1): push {ext, rel, byte}, then clear both flags.
  - States: IDLE, EXT, REL, EXT_REL. E0 followed by F0 reaches EXT_REL.
- **Raw mode** (DECODE_PREFIX=0): every good byte is pushed with ext=0 and rel=0.
- **FIFO**: entries are 10 bits wide.
  - Push when not full: store the entry and pulse interrupt.
  - Push when full: drop the entry and pulse overflow. interrupt does not pulse and the decoder flags still clear.
  - Pop occurs on out_valid && out_ready.
  - Simultaneous push and pop when full: both succeed and fifo_count is unchanged.
  - Simultaneous push and pop when empty: the new entry is written and out_valid rises the next cycle.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- **Output hold**: out_code, out_extended and out_release show the head entry. They are held stable while out_valid=1 and out_ready=0.

## Timing
- **Reset**: while reset_n=0, every output is 0 (out_valid, out_code, out_extended, out_release, interrupt, frame_error, overflow, fifo_count). Also, the FIFO is empty, the decoder is IDLE, the bit count is 0 and the timeout counter is 0.
- **Reset mid-frame**: the partial frame is lost. Reception restarts cleanly on the next start bit.
- **Edge to sample**: an edge at the pin is accepted 2 (synchroniser) + SAMPLE_DELAY + 1 cycles later. Any clock glitch shorter than SAMPLE_DELAY cycles is ignored.
- **Stop bit to output**: call the stop-bit capture cycle N.
  - Cycle N+1: decode and check.
  - Cycle N+2: FIFO write; interrupt pulses at the N+2 edge.
  - From N+2 on: out_valid=1 when the FIFO was previously empty.
- **Error pulses**: frame_error and overflow each pulse for exactly one cycle per event, aligned with the cycle a push would have occurred.
- **Count update**: fifo_count updates on the same edge as the push or pop.

## Test plan
- **Make code**: frame 0x1C (parity 0, stop 1), out_ready=1 → one entry code=0x1C, ext=0, rel=0; interrupt pulses once; fifo_count returns to 0 after the pop.
- **Extended break**: frames E0, F0, 75 → a single entry code=0x75, ext=1, rel=1. No entries for E0 or F0. Repeat with DECODE_PREFIX=0 → three raw entries E0, F0, 75.
- **Parity error**: frame 0x1C with parity bit 1 → frame_error pulses, no push. A following good F0, 1C → code=0x1C, rel=1, ext=0, confirming the prefix state was cleared only by the error.
- **Overflow**: out_ready=0, FIFO_DEPTH=8, send 9 frames 0x01–0x09 → fifo_count=8 and overflow pulses once (for 0x09). Raising out_ready pops 0x01–0x08 in order, and out_valid drops after 0x08.
- **Timeout**: send 5 bits then hold the bus idle for >3200 cycles → frame_error pulses once and the count resets. The next full 0x29 frame decodes correctly.
- **Glitch and reset**: a 5-cycle low pulse on kbd_clk while idle → no bit captured. Asserting reset_n=0 at bit 6 of a frame → all outputs 0 the next cycle, and a fresh 0x1C after release decodes.
